// File: rtl/enemy_run_anim_ctrl_if.sv
// Pixel-fetch bus between the enemy controller, the video timing, the sprite ROM
// and the frame compositor.
interface enemy_run_anim_ctrl_if #(
  parameter int SPR_W   = 32,
  parameter int SPR_H   = 32,
  parameter int NUM_RUN = 6,
  parameter int NUM_DIE = 3
);
  localparam int ADDR_W = $clog2((NUM_RUN + NUM_DIE) * SPR_W * SPR_H);

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [ADDR_W-1:0] rom_addr;
  logic [2:0]        rom_index;
  logic [2:0]        pal_index;
  logic              pixel_valid;

  modport master (
    input  DrawX, DrawY, rom_index,
    output rom_addr, pal_index, pixel_valid
  );

  modport slave (
    output DrawX, DrawY, rom_index,
    input  rom_addr, pal_index, pixel_valid
  );
endinterface

// File: rtl/enemy_run_anim_ctrl.sv
// Running enemy sprite: movement, run/death animation FSM and a fixed 3-cycle
// pixel fetch pipeline (box test + ROM address, ROM read, palette/opaque flag).
//
// state | meaning
// IDLE  | no enemy on screen, waiting for spawn
// RUN   | moving SPEED px per frame_tick, cycling run frames
// DYING | frozen in place, playing death frames once, then IDLE
module enemy_run_anim_ctrl #(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int NUM_RUN     = 6,
  parameter int NUM_DIE     = 3,
  parameter int FRAME_TICKS = 6,
  parameter int SPEED       = 2,
  parameter int SCREEN_W    = 640
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  logic       spawn_dir,
  input  logic       hit,
  enemy_run_anim_ctrl_if.master pix,
  output logic       active,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);

  localparam int ADDR_W  = $clog2((NUM_RUN + NUM_DIE) * SPR_W * SPR_H);
  localparam int FRAME_W = $clog2(NUM_RUN + NUM_DIE);
  localparam int TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int COL_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int ROW_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DYING = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [9:0]          pos_x_n, pos_y_n;
  logic                dir, dir_n;
  logic [FRAME_W-1:0]  frame, frame_n;
  logic [TICK_W-1:0]   tick_cnt, tick_n;

  logic                tick_wrap;
  logic                at_edge;

  assign active    = (state != IDLE);
  assign tick_wrap = (tick_cnt == TICK_W'(FRAME_TICKS - 1));

  // Stop before the move that would put any part of the sprite off screen.
  assign at_edge = dir ? (({1'b0, pos_x} + 11'(SPR_W + SPEED)) > 11'(SCREEN_W))
                       : (pos_x < 10'(SPEED));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      pos_x    <= '0;
      pos_y    <= '0;
      dir      <= 1'b0;
      frame    <= '0;
      tick_cnt <= '0;
    end else begin
      state    <= state_n;
      pos_x    <= pos_x_n;
      pos_y    <= pos_y_n;
      dir      <= dir_n;
      frame    <= frame_n;
      tick_cnt <= tick_n;
    end
  end

  always_comb begin
    state_n = state;
    pos_x_n = pos_x;
    pos_y_n = pos_y;
    dir_n   = dir;
    frame_n = frame;
    tick_n  = tick_cnt;
    unique case (state)
      IDLE: begin
        if (spawn) begin
          state_n = RUN;
          pos_x_n = spawn_x;
          pos_y_n = spawn_y;
          dir_n   = spawn_dir;
          frame_n = '0;
          tick_n  = '0;
        end
      end
      RUN: begin
        if (hit) begin
          state_n = DYING;
          frame_n = FRAME_W'(NUM_RUN);
          tick_n  = '0;
        end else if (frame_tick) begin
          if (at_edge) begin
            state_n = IDLE;
          end else begin
            pos_x_n = dir ? (pos_x + 10'(SPEED)) : (pos_x - 10'(SPEED));
            if (tick_wrap) begin
              tick_n  = '0;
              frame_n = (frame == FRAME_W'(NUM_RUN - 1)) ? '0 : frame + 1'b1;
            end else begin
              tick_n = tick_cnt + 1'b1;
            end
          end
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (tick_wrap) begin
            tick_n = '0;
            if (frame == FRAME_W'(NUM_RUN + NUM_DIE - 1)) begin
              state_n = IDLE;
            end else begin
              frame_n = frame + 1'b1;
            end
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage 1: box test and ROM address. 11-bit compares so pos+SPR_W never wraps.
  logic [10:0]       draw_x_e, draw_y_e, pos_x_e, pos_y_e;
  logic              in_box_c;
  logic [COL_W-1:0]  col_raw, col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] addr_c;

  assign draw_x_e = {1'b0, pix.DrawX};
  assign draw_y_e = {1'b0, pix.DrawY};
  assign pos_x_e  = {1'b0, pos_x};
  assign pos_y_e  = {1'b0, pos_y};

  assign in_box_c = active
                  && (draw_x_e >= pos_x_e) && (draw_x_e < pos_x_e + 11'(SPR_W))
                  && (draw_y_e >= pos_y_e) && (draw_y_e < pos_y_e + 11'(SPR_H));

  assign col_raw = COL_W'(draw_x_e - pos_x_e);
  assign row     = ROW_W'(draw_y_e - pos_y_e);
  assign col     = dir ? (COL_W'(SPR_W - 1) - col_raw) : col_raw;

  assign addr_c = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(row)   * ADDR_W'(SPR_W)
                + ADDR_W'(col);

  logic in_box_d1, in_box_d2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix.rom_addr    <= '0;
      in_box_d1       <= 1'b0;
      in_box_d2       <= 1'b0;
      pix.pal_index   <= '0;
      pix.pixel_valid <= 1'b0;
    end else begin
      pix.rom_addr    <= in_box_c ? addr_c : '0;
      in_box_d1       <= in_box_c;
      in_box_d2       <= in_box_d1;
      pix.pal_index   <= in_box_d2 ? pix.rom_index : 3'd0;
      pix.pixel_valid <= in_box_d2 && (pix.rom_index != 3'd0);
    end
  end

endmodule

// File: tb/tb_enemy_run_anim_ctrl.sv
// Bench for enemy_run_anim_ctrl: directed vector table, hand-written pipeline
// sequences and randomized traffic, all checked against a count-based model.
module tb_enemy_run_anim_ctrl;
  localparam int SPR_W = 32, SPR_H = 32, NUM_RUN = 6, NUM_DIE = 3;
  localparam int FRAME_TICKS = 6, SPEED = 2, SCREEN_W = 640;

  logic       Clk = 1'b0;
  logic       Reset, frame_tick, spawn, spawn_dir, hit;
  logic [9:0] spawn_x, spawn_y;
  logic       active;
  logic [9:0] pos_x, pos_y;

  enemy_run_anim_ctrl_if pix ();

  enemy_run_anim_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .spawn(spawn),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir), .hit(hit),
    .pix(pix), .active(active), .pos_x(pos_x), .pos_y(pos_y)
  );

  always #5 Clk = ~Clk;

  logic [2:0] rom_mem [16384];
  always @(posedge Clk) pix.rom_index <= rom_mem[pix.rom_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position plus counts of frame_ticks spent running / dying.
  bit m_act, m_dying, m_dir;
  int m_x, m_y, n_run, n_die;

  function automatic int m_frame();
    return m_dying ? NUM_RUN + n_die / FRAME_TICKS : (n_run / FRAME_TICKS) % NUM_RUN;
  endfunction

  task automatic model_step(input bit sp, input bit h, input bit ft,
                            input int sx, input int sy, input bit sd);
    if (!m_act) begin
      if (sp) begin
        m_act = 1; m_dying = 0; m_x = sx; m_y = sy; m_dir = sd; n_run = 0;
      end
    end else if (!m_dying) begin
      if (h) begin
        m_dying = 1; n_die = 0;
      end else if (ft) begin
        if ((!m_dir && m_x < SPEED) || (m_dir && m_x + SPR_W + SPEED > SCREEN_W))
          m_act = 0;
        else begin
          m_x = m_dir ? m_x + SPEED : m_x - SPEED;
          n_run++;
        end
      end
    end else if (ft) begin
      n_die++;
      if (n_die == NUM_DIE * FRAME_TICKS) begin
        m_act = 0; m_dying = 0;
      end
    end
  endtask

  typedef struct { int addr; int pal; int valid; } pix_t;
  pix_t hist [3];

  function automatic pix_t exp_pix(input int dx, input int dy);
    pix_t e;
    int col;
    e = '{0, 0, 0};
    if (m_act && dx >= m_x && dx < m_x + SPR_W && dy >= m_y && dy < m_y + SPR_H) begin
      col = dx - m_x;
      if (m_dir) col = SPR_W - 1 - col;
      e.addr  = m_frame() * SPR_W * SPR_H + (dy - m_y) * SPR_W + col;
      e.pal   = int'(rom_mem[e.addr]);
      e.valid = (e.pal != 0) ? 1 : 0;
    end
    return e;
  endfunction

  // One clock: drive at negedge, advance model, check everything at next negedge.
  task automatic cycle(input bit r, input bit sp, input bit h, input bit ft,
                       input int sx, input int sy, input bit sd,
                       input int dx, input int dy);
    Reset = r; spawn = sp; hit = h; frame_tick = ft;
    spawn_x = 10'(sx); spawn_y = 10'(sy); spawn_dir = sd;
    pix.DrawX = 10'(dx); pix.DrawY = 10'(dy);
    if (r) begin
      m_act = 0; m_dying = 0; m_dir = 0; m_x = 0; m_y = 0; n_run = 0; n_die = 0;
      for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0};
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = exp_pix(dx & 1023, dy & 1023);
      model_step(sp, h, ft, sx, sy, sd);
    end
    @(posedge Clk);
    @(negedge Clk);
    chk("rom_addr", int'(pix.rom_addr), hist[0].addr);
    chk("pal_index", int'(pix.pal_index), hist[2].pal);
    chk("pixel_valid", int'(pix.pixel_valid), hist[2].valid);
    chk("active", int'(active), int'(m_act));
    chk("pos_x", int'(pos_x), m_x);
    chk("pos_y", int'(pos_y), m_y);
  endtask

  function automatic int near(input int p);
    return (p + int'($urandom_range(0, 44)) - 6) & 1023;
  endfunction

  typedef struct {
    bit rst, sp, h, ft;
    int sx, sy;
    bit sd;
    int rep;
    bit chk_en;
    bit e_act;
    int e_x;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  initial begin
    vt[0]  = '{1, 0, 0, 0,   0,   0, 0,  2, 1, 0,   0};
    vt[1]  = '{0, 1, 0, 0, 300, 200, 0,  1, 1, 1, 300};
    vt[2]  = '{0, 0, 0, 1,   0,   0, 0, 12, 1, 1, 276};
    vt[3]  = '{0, 0, 1, 1,   0,   0, 0,  1, 1, 1, 276};
    vt[4]  = '{0, 0, 0, 1,   0,   0, 0, 17, 1, 1, 276};
    vt[5]  = '{0, 0, 0, 1,   0,   0, 0,  1, 1, 0, 276};
    vt[6]  = '{0, 1, 0, 0,   3,  40, 0,  1, 1, 1,   3};
    vt[7]  = '{0, 0, 0, 1,   0,   0, 0,  1, 1, 1,   1};
    vt[8]  = '{0, 0, 0, 1,   0,   0, 0,  1, 1, 0,   1};
    vt[9]  = '{0, 0, 1, 0,   0,   0, 0,  1, 1, 0,   1};
    vt[10] = '{0, 1, 1, 0, 100,  50, 1,  1, 1, 1, 100};
    vt[11] = '{0, 0, 0, 1,   0,   0, 0,  1, 1, 1, 102};
    vt[12] = '{0, 1, 0, 0, 500,  60, 0,  1, 1, 1, 102};
    vt[13] = '{0, 0, 0, 1,   0,   0, 0,  5, 1, 1, 112};
    vt[14] = '{1, 0, 0, 0,   0,   0, 0,  2, 1, 0,   0};
    vt[15] = '{0, 0, 0, 0,   0,   0, 0,  1, 1, 0,   0};
    vt[16] = '{0, 1, 0, 0, 604, 100, 1,  1, 1, 1, 604};
    vt[17] = '{0, 0, 0, 1,   0,   0, 0,  2, 1, 1, 608};
    vt[18] = '{0, 0, 0, 1,   0,   0, 0,  1, 1, 0, 608};
    vt[19] = '{0, 0, 0, 0,   0,   0, 0,  1, 1, 0, 608};

    for (int a = 0; a < 16384; a++) rom_mem[a] = 3'($urandom_range(0, 7));
    rom_mem[101] = 3'd5;
    rom_mem[122] = 3'd0;
    rom_mem[96]  = 3'd3;
    rom_mem[127] = 3'd3;
    pix.rom_index = 3'd0;

    Reset = 1; spawn = 0; hit = 0; frame_tick = 0;
    spawn_x = 0; spawn_y = 0; spawn_dir = 0; pix.DrawX = 0; pix.DrawY = 0;
    @(negedge Clk);

    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < vt[v].rep; k++)
        cycle(vt[v].rst, vt[v].sp, vt[v].h, vt[v].ft, vt[v].sx, vt[v].sy, vt[v].sd,
              near(m_x), near(m_y));
      if (vt[v].chk_en) begin
        chk($sformatf("vec%0d_active", v), int'(active), int'(vt[v].e_act));
        chk($sformatf("vec%0d_pos_x", v), int'(pos_x), vt[v].e_x);
      end
    end

    // Pipeline latency and address, dir=0.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 300, 200, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 305, 203);
    chk("addr_dir0", int'(pix.rom_addr), 101);
    cycle(0, 0, 0, 0, 0, 0, 0, 332, 203);
    cycle(0, 0, 0, 0, 0, 0, 0, 299, 203);
    chk("pal_t3", int'(pix.pal_index), 5);
    chk("valid_t3", int'(pix.pixel_valid), 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("valid_right_edge", int'(pix.pixel_valid), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("valid_left_edge", int'(pix.pixel_valid), 0);

    // Mirrored address, transparent index.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 300, 200, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 305, 203);
    chk("addr_dir1", int'(pix.rom_addr), 122);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("valid_transparent", int'(pix.pixel_valid), 0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      bit r, sp, h, ft, sd;
      int dx, dy;
      r  = ($urandom_range(0, 599) == 0);
      sp = ($urandom_range(0, 19) == 0);
      h  = ($urandom_range(0, 39) == 0);
      ft = ($urandom_range(0, 2) == 0);
      sd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        dx = int'($urandom_range(0, 1023));
        dy = int'($urandom_range(0, 1023));
      end else begin
        dx = near(m_x);
        dy = near(m_y);
      end
      cycle(r, sp, h, ft, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            sd, dx, dy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
